// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB types, sizes and requester indices for the CDB arbiter.
package cdb_arbiter_pkg;
    localparam int NUM_CDB_ENTRIES = 3;
    localparam int RO_BUFFER_ENTRIES = 16;
    localparam int TAG_W = $clog2(RO_BUFFER_ENTRIES);
    localparam int CDB_NUM_REQ = 6;
    typedef enum logic [2:0] {
        REQ_ALU0,
        REQ_ALU1,
        REQ_ALU2,
        REQ_ALU3,
        REQ_CMP,
        REQ_LSU
    } req_idx_e;
    typedef struct packed {
        logic valid;
        logic [TAG_W-1:0] tag;
        logic [31:0] value;
    } cdb_entry_t;
    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer request/grant bundle plus registered CDB broadcast.
// CDB_ARB_STATS_EN adds the stall statistics outputs.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
    parameter int N_REQ = CDB_NUM_REQ
);
    logic flush;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0][TAG_W-1:0] req_tag;
    logic [N_REQ-1:0][31:0] req_value;
    logic [N_REQ-1:0] req_ready;
    cdb_t cdb_o;
    logic arb_busy;
`ifdef CDB_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] stall_cnt;
    logic [7:0] max_wait;
    modport master (output flush, req_valid, req_tag, req_value,
                    input req_ready, cdb_o, arb_busy, stall_cnt, max_wait);
    modport slave (input flush, req_valid, req_tag, req_value,
                   output req_ready, cdb_o, arb_busy, stall_cnt, max_wait);
`else
    modport master (output flush, req_valid, req_tag, req_value,
                    input req_ready, cdb_o, arb_busy);
    modport slave (input flush, req_valid, req_tag, req_value,
                   output req_ready, cdb_o, arb_busy);
`endif
endinterface

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// rr_multi_pick: combinational round-robin pick of up to K requesters starting at ptr.
module rr_multi_pick #(
    parameter int N = 6,
    parameter int K = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [K-1:0] lane_vld,
    output logic [K-1:0][IW-1:0] lane_idx,
    output logic [IW-1:0] last
);
    logic [N-1:0] rot, rem;
    logic [IW-1:0] pos, idx;
    logic found;

    function automatic logic [IW-1:0] unrot(input logic [IW-1:0] p, input logic [IW-1:0] base);
        logic [IW:0] s;
        s = {1'b0, p} + {1'b0, base};
        return (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : IW'(s);
    endfunction

    // rot[j] is requester (ptr+j) mod N, so scan order becomes plain LSB-first
    always_comb begin
        rot = N'({req, req} >> ptr);
        rem = rot;
        grant = '0;
        lane_vld = '0;
        lane_idx = '0;
        last = '0;
        pos = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < K; k++) begin
            pos = '0;
            found = 1'b0;
            for (int b = N - 1; b >= 0; b--) begin
                if (rem[b]) begin
                    pos = IW'(b);
                    found = 1'b1;
                end
            end
            idx = unrot(pos, ptr);
            if (found) begin
                rem[pos] = 1'b0;
                lane_vld[k] = 1'b1;
                lane_idx[k] = idx;
                grant[idx] = 1'b1;
                last = idx;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin multi-lane arbiter registering producer results onto the CDB.
// CDB_ARB_STATS_EN adds per-requester stall counters and a max consecutive-wait register.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int N_REQ = CDB_NUM_REQ
) (
    input logic clk,
    input logic rst,
    cdb_arbiter_if.slave bus
);
    localparam int NUM_LANES = NUM_CDB_ENTRIES;
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0] grant;
    logic [NUM_LANES-1:0] lane_vld;
    logic [NUM_LANES-1:0][IW-1:0] lane_idx;
    logic [IW-1:0] last, rr_ptr;
    cdb_t cdb_nx;

    rr_multi_pick #(.N(N_REQ), .K(NUM_LANES)) u_pick (
        .req(bus.req_valid),
        .ptr(rr_ptr),
        .grant(grant),
        .lane_vld(lane_vld),
        .lane_idx(lane_idx),
        .last(last)
    );

    assign bus.req_ready = (rst || bus.flush) ? '0 : grant;

    always_comb begin
        cdb_nx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cdb_nx[k].valid = lane_vld[k];
            cdb_nx[k].tag = lane_vld[k] ? bus.req_tag[lane_idx[k]] : '0;
            cdb_nx[k].value = lane_vld[k] ? bus.req_value[lane_idx[k]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.cdb_o <= '0;
            rr_ptr <= '0;
            bus.arb_busy <= 1'b0;
        end else begin
            bus.cdb_o <= cdb_nx;
            if (|grant) rr_ptr <= (last == IW'(N_REQ - 1)) ? '0 : last + 1'b1;
            bus.arb_busy <= $countones(bus.req_valid) > NUM_LANES;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [N_REQ-1:0] stalled;
    logic [N_REQ-1:0][7:0] run, run_nx;
    logic [7:0] max_nx;

    assign stalled = bus.req_valid & ~bus.req_ready;

    always_comb begin
        run_nx = '0;
        max_nx = bus.max_wait;
        for (int i = 0; i < N_REQ; i++) begin
            run_nx[i] = stalled[i] ? ((run[i] == 8'hFF) ? 8'hFF : run[i] + 8'd1) : 8'd0;
            max_nx = (run_nx[i] > max_nx) ? run_nx[i] : max_nx;
        end
    end

    // statistics survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt <= '0;
            run <= '0;
            bus.max_wait <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (stalled[i] && bus.stall_cnt[i] != 16'hFFFF) bus.stall_cnt[i] <= bus.stall_cnt[i] + 16'd1;
            run <= run_nx;
            bus.max_wait <= max_nx;
        end
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized producers checked against a queue-based scan model.
// Stats outputs are checked when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if bus();
    cdb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [5:0] vld;
    logic [3:0] tag[6];
    logic [31:0] val[6];
    int m_rr;
    logic [5:0] m_ready;
    cdb_entry_t m_cdb[3];
    logic m_busy;
    int m_stall[6], m_run[6], m_max;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    // requesters in rotated order go into a queue; the first three win
    task automatic model(input logic r, input logic fl);
        int q[$];
        int n;
        m_ready = '0;
        for (int k = 0; k < 3; k++) m_cdb[k] = '0;
        if (r || fl) begin
            m_rr = 0;
            m_busy = 1'b0;
        end else begin
            for (int j = 0; j < 6; j++)
                if (vld[(m_rr + j) % 6]) q.push_back((m_rr + j) % 6);
            n = (q.size() < 3) ? q.size() : 3;
            for (int k = 0; k < n; k++) begin
                m_ready[q[k]] = 1'b1;
                m_cdb[k] = '{1'b1, tag[q[k]], val[q[k]]};
            end
            if (n > 0) m_rr = (q[n-1] + 1) % 6;
            m_busy = q.size() > 3;
        end
        for (int i = 0; i < 6; i++) begin
            if (r) begin
                m_stall[i] = 0;
                m_run[i] = 0;
            end else if (vld[i] && !m_ready[i]) begin
                m_stall[i] = (m_stall[i] < 65535) ? m_stall[i] + 1 : 65535;
                m_run[i] = (m_run[i] < 255) ? m_run[i] + 1 : 255;
            end else m_run[i] = 0;
        end
        if (r) m_max = 0;
        for (int i = 0; i < 6; i++) m_max = (m_run[i] > m_max) ? m_run[i] : m_max;
    endtask

    task automatic cycle(input logic r, input logic fl);
        rst = r;
        bus.flush = fl;
        bus.req_valid = vld;
        for (int i = 0; i < 6; i++) begin
            bus.req_tag[i] = tag[i];
            bus.req_value[i] = val[i];
        end
        #1;
        model(r, fl);
        chk("req_ready", bus.req_ready, m_ready);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("lane%0d", k), bus.cdb_o[k], m_cdb[k]);
        chk("arb_busy", bus.arb_busy, m_busy);
`ifdef CDB_ARB_STATS_EN
        for (int i = 0; i < 6; i++) chk($sformatf("stall_cnt%0d", i), bus.stall_cnt[i], m_stall[i]);
        chk("max_wait", bus.max_wait, m_max);
`endif
        vld = (r || fl) ? '0 : (vld & ~m_ready);
    endtask

    task automatic set_idx_tags();
        for (int i = 0; i < 6; i++) begin
            tag[i] = 4'(i);
            val[i] = 32'h1000 + i;
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.req_valid = '0;
        bus.req_tag = '0;
        bus.req_value = '0;
        vld = '0;
        m_rr = 0;
        m_max = 0;
        for (int i = 0; i < 6; i++) begin
            m_stall[i] = 0;
            m_run[i] = 0;
        end
        set_idx_tags();
        @(negedge clk);
        cycle(1'b1, 1'b0);
        vld = '1;
        cycle(1'b1, 1'b0);
        chk("rst_cdb", bus.cdb_o, '0);
        chk("rst_busy", bus.arb_busy, 1'b0);
        vld = '1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
`ifdef CDB_ARB_STATS_EN
        chk("stats_cnt5", bus.stall_cnt[REQ_LSU], 16'd1);
        chk("stats_max_ge1", bus.max_wait >= 8'd1, 1'b1);
`endif
        for (int c = 0; c < 3; c++) begin
            vld = '1;
            cycle(1'b0, 1'b0);
            for (int k = 0; k < 3; k++)
                chk($sformatf("over_c%0d_l%0d", c, k), bus.cdb_o[k].tag, 4'((c % 2) * 3 + k));
            chk($sformatf("over_busy%0d", c), bus.arb_busy, 1'b1);
        end
        vld = 6'b000100;
        tag[2] = 4'd5;
        val[2] = 32'hDEADBEEF;
        cycle(1'b0, 1'b0);
        chk("single_l0", bus.cdb_o[0], {1'b1, 4'd5, 32'hDEADBEEF});
        chk("single_l1", bus.cdb_o[1], '0);
        chk("single_l2", bus.cdb_o[2], '0);
        set_idx_tags();
        vld = 6'b001000;
        cycle(1'b0, 1'b0);
        vld = 6'b110010;
        cycle(1'b0, 1'b0);
        chk("wrap_l0", bus.cdb_o[0].tag, 4'd4);
        chk("wrap_l1", bus.cdb_o[1].tag, 4'd5);
        chk("wrap_l2", bus.cdb_o[2].tag, 4'd1);
        vld = '1;
        cycle(1'b0, 1'b0);
        chk("wrap_ptr2", bus.cdb_o[0].tag, 4'd2);
        vld = 6'b001001;
        cycle(1'b0, 1'b1);
        chk("flush_l0", bus.cdb_o[0].valid, 1'b0);
        vld = '1;
        cycle(1'b0, 1'b0);
        chk("flush_ptr0", bus.cdb_o[0].tag, 4'd0);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 6; i++) begin
                if (!vld[i] && $urandom_range(0, 99) < 60) begin
                    vld[i] = 1'b1;
                    tag[i] = 4'($urandom);
                    val[i] = $urandom;
                end
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 5);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
